// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared defaults and FSM state type for the lstm cell sequencer
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;
  localparam int LSTM_LEN_W       = 8;
  localparam int LSTM_CELL_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    EMIT = 2'd3
  } lstm_state_t;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - runs a combinational lstm_cell over a sequence of timesteps
// Owns the recurrent c/h state; the cell path is treated as a CELL_LAT-cycle multicycle path.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int LEN_W       = LSTM_LEN_W,
  parameter int CELL_LAT    = LSTM_CELL_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      seq_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      t_idx,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  h_valid,
  input  logic                  h_ready,
  output logic [DATA_WIDTH-1:0] h_data,
  output logic [DATA_WIDTH-1:0] c_final,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out
);

  localparam int LAT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CELL_LAT - 1);

  // Fixed-point format is only carried through; the block never does arithmetic on data.
  if (FRACT_WIDTH >= DATA_WIDTH || CELL_LAT < 1) begin : g_param_range
  end

  lstm_state_t           r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_t;
  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] r_h;
  logic [DATA_WIDTH-1:0] r_c_final;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_x_ready;
  logic                  r_h_valid;

  logic                  w_last_step;

  // Compare against len-1 rather than counting to len so a max-length run never wraps t_idx.
  assign w_last_step = (r_t == (r_len - 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_t       <= '0;
      r_lat     <= '0;
      r_x       <= '0;
      r_c       <= '0;
      r_h       <= '0;
      r_c_final <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_x_ready <= 1'b0;
      r_h_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_len     <= seq_len;
              r_t       <= '0;
              r_c       <= '0;
              r_h       <= '0;
              r_busy    <= 1'b1;
              r_x_ready <= 1'b1;
              r_state   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (x_valid) begin
            r_x       <= x_data;
            r_x_ready <= 1'b0;
            r_lat     <= '0;
            r_state   <= EVAL;
          end
        end
        EVAL: begin
          // Cell inputs are held constant here, so the capture sees fully settled outputs.
          if (r_lat == LAT_LAST) begin
            r_c       <= cell_c_out;
            r_h       <= cell_h_out;
            r_h_valid <= 1'b1;
            r_state   <= EMIT;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        EMIT: begin
          if (h_ready) begin
            r_h_valid <= 1'b0;
            if (w_last_step) begin
              r_c_final <= r_c;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_t       <= r_t + 1'b1;
              r_x_ready <= 1'b1;
              r_state   <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign t_idx   = r_t;
  assign x_ready = r_x_ready;
  assign h_valid = r_h_valid;
  assign h_data  = r_h;
  assign c_final = r_c_final;
  assign cell_x  = r_x;
  assign cell_c  = r_c;
  assign cell_h  = r_h;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - directed bench for lstm_seq_ctrl with a stub cell (c+X, X)
module tb_lstm_seq_ctrl;

  localparam int DW       = 16;
  localparam int LW       = 8;
  localparam int CELL_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic          busy, done, x_ready, h_valid;
  logic [LW-1:0] t_idx;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          h_ready = 1'b1;
  logic [DW-1:0] h_data, c_final, cell_x, cell_c, cell_h;
  logic [DW-1:0] cell_c_out, cell_h_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  logic [DW-1:0] last_x = '0;

  typedef struct {
    int          len;
    logic [15:0] x_base;
    logic [15:0] x_inc;
    int          gap;
    int          hold;
    bit          mid_start;
    logic [15:0] exp_cfinal;
  } vec_t;

  vec_t vecs[8];
  vec_t post_rst;

  always #5 clk = ~clk;

  assign cell_c_out = cell_c + cell_x;
  assign cell_h_out = cell_x;

  lstm_seq_ctrl #(
    .DATA_WIDTH (DW),
    .FRACT_WIDTH(8),
    .LEN_W      (LW),
    .CELL_LAT   (CELL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seq_len   (seq_len),
    .busy      (busy),
    .done      (done),
    .t_idx     (t_idx),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .h_valid   (h_valid),
    .h_ready   (h_ready),
    .h_data    (h_data),
    .c_final   (c_final),
    .cell_x    (cell_x),
    .cell_c    (cell_c),
    .cell_h    (cell_h),
    .cell_c_out(cell_c_out),
    .cell_h_out(cell_h_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seq(input vec_t v);
    logic [DW-1:0] x;
    logic [DW-1:0] exp_c;
    logic [DW-1:0] exp_h;
    int            k;
    exp_c   = '0;
    exp_h   = '0;
    h_ready = (v.hold == 0);
    seq_len = v.len[LW-1:0];
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk_b("busy_on", busy, 1'b1);
    chk_n("t_idx_start", int'(t_idx), 0);
    chk_b("x_ready_load", x_ready, 1'b1);
    for (int i = 0; i < v.len; i++) begin
      x = v.x_base + 16'(i) * v.x_inc;
      if (i == 0) begin
        for (int g = 0; g < v.gap; g++) begin
          x_valid = 1'b0;
          x_data  = 16'hDEAD;
          step();
          chk_b("gap_x_ready", x_ready, 1'b1);
          chk_b("gap_h_valid", h_valid, 1'b0);
          chk_w("gap_cell_x", cell_x, last_x);
        end
      end
      x_valid = 1'b1;
      x_data  = x;
      k = 0;
      while (!x_ready && k < 50) begin
        step();
        k++;
      end
      chk_b("x_ready_wait", x_ready, 1'b1);
      step();
      x_valid = 1'b0;
      x_data  = ~x;
      last_x  = x;
      chk_w("cell_x", cell_x, x);
      chk_w("cell_c", cell_c, exp_c);
      chk_w("cell_h", cell_h, exp_h);
      n = 1;
      if (v.mid_start && i == 1) begin
        start   = 1'b1;
        seq_len = 8'd9;
        step();
        start   = 1'b0;
        seq_len = '0;
        n++;
        chk_b("mid_start_busy", busy, 1'b1);
      end
      while (!h_valid && n < 50) begin
        step();
        n++;
      end
      chk_n("latency", n, CELL_LAT + 1);
      exp_c = exp_c + x;
      exp_h = x;
      chk_w("h_data", h_data, x);
      chk_n("t_idx", int'(t_idx), i);
      chk_b("x_ready_emit", x_ready, 1'b0);
      if (i == 0 && v.hold > 0) begin
        for (int h = 0; h < v.hold; h++) begin
          step();
          chk_b("hold_h_valid", h_valid, 1'b1);
          chk_w("hold_h_data", h_data, x);
          chk_b("hold_x_ready", x_ready, 1'b0);
        end
        h_ready = 1'b1;
      end
      step();
      chk_b("h_valid_drop", h_valid, 1'b0);
      if (i == v.len - 1) begin
        chk_b("done_pulse", done, 1'b1);
        chk_b("busy_off", busy, 1'b0);
        chk_w("c_final", c_final, v.exp_cfinal);
      end else begin
        chk_b("done_early", done, 1'b0);
        chk_b("x_ready_next", x_ready, 1'b1);
        chk_n("t_idx_next", int'(t_idx), i + 1);
      end
    end
    step();
    chk_b("done_single", done, 1'b0);
    chk_w("c_final_hold", c_final, v.exp_cfinal);
  endtask

  initial begin
    vecs[0] = '{3,   16'd1,     16'd1, 0, 0, 1'b0, 16'd6};
    vecs[1] = '{1,   16'h7FFF,  16'd0, 0, 0, 1'b0, 16'h7FFF};
    vecs[2] = '{2,   16'hFFFF,  16'd3, 0, 0, 1'b0, 16'h0001};
    vecs[3] = '{4,   16'h8000,  16'd0, 0, 0, 1'b0, 16'h0000};
    vecs[4] = '{3,   16'd1,     16'd1, 4, 0, 1'b0, 16'd6};
    vecs[5] = '{2,   16'h1234,  16'd1, 0, 5, 1'b0, 16'h2469};
    vecs[6] = '{3,   16'd1,     16'd1, 0, 0, 1'b1, 16'd6};
    vecs[7] = '{255, 16'd1,     16'd0, 0, 0, 1'b0, 16'h00FF};
    post_rst = '{2,  16'd3,     16'd1, 0, 0, 1'b0, 16'd7};

    repeat (3) step();
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_x_ready", x_ready, 1'b0);
    chk_b("rst_h_valid", h_valid, 1'b0);
    chk_n("rst_t_idx", int'(t_idx), 0);
    chk_w("rst_c_final", c_final, 16'h0);
    chk_w("rst_h_data", h_data, 16'h0);
    chk_w("rst_cell_x", cell_x, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int v = 0; v < 8; v++) run_seq(vecs[v]);

    seq_len = '0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk_b("len0_done", done, 1'b1);
    chk_b("len0_busy", busy, 1'b0);
    chk_b("len0_x_ready", x_ready, 1'b0);
    chk_b("len0_h_valid", h_valid, 1'b0);
    step();
    chk_b("len0_done_single", done, 1'b0);
    chk_b("len0_busy_after", busy, 1'b0);
    chk_b("len0_x_ready_after", x_ready, 1'b0);
    chk_w("len0_c_final", c_final, 16'h00FF);

    h_ready = 1'b1;
    seq_len = 8'd3;
    start   = 1'b1;
    step();
    start   = 1'b0;
    x_valid = 1'b1;
    x_data  = 16'd5;
    step();
    x_valid = 1'b0;
    n = 1;
    while (!h_valid && n < 50) begin
      step();
      n++;
    end
    chk_w("mr_h_data", h_data, 16'd5);
    step();
    x_valid = 1'b1;
    x_data  = 16'd6;
    step();
    x_valid = 1'b0;
    chk_w("mr_cell_c", cell_c, 16'd5);
    #2 rst = 1'b0;
    #1;
    chk_b("mr_busy", busy, 1'b0);
    chk_b("mr_done", done, 1'b0);
    chk_b("mr_h_valid", h_valid, 1'b0);
    chk_b("mr_x_ready", x_ready, 1'b0);
    chk_n("mr_t_idx", int'(t_idx), 0);
    chk_w("mr_cell_x", cell_x, 16'h0);
    chk_w("mr_cell_c0", cell_c, 16'h0);
    chk_w("mr_cell_h", cell_h, 16'h0);
    chk_w("mr_c_final", c_final, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_b("mr_idle", busy, 1'b0);
    last_x = '0;
    run_seq(post_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
